spi_mem_ctrl: RTL and testbench

Parametrised SPI memory controller. It is the next generation of the single-flash/single-PSRAM controller in the MCU memory path. It serves one request at a time over a shared SCLK/MOSI/MISO bus with NUM_CS active-low chip selects, and supports variable-length bursts (1..MAX_BYTES) and a programmable SCLK divider. The sequencer issues fetch, load and store requests through a valid/ready handshake and receives a done pulse with read data.

---
 rtl/spi_mem_ctrl_pkg.sv | 26 ++
 rtl/spi_mem_ctrl_clk_phase.sv | 44 ++++
 rtl/spi_mem_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_ctrl_pkg.sv
// spi_mem_ctrl_pkg: shared types and constants for the SPI memory controller.
//   spi_mem_state_t   : controller FSM state encoding
//   SPI_CMD_*         : SPI opcodes (read, fast read, write)
//   SPI_ADDR_BITS     : wire address width (always 24 bits, MSB first)
//   max_int()         : elaboration-time helper for width calculations
package spi_mem_ctrl_pkg;

  localparam logic [7:0] SPI_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] SPI_CMD_WRITE     = 8'h02;
  localparam int         SPI_ADDR_BITS     = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } spi_mem_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_clk_phase.sv
// spi_clk_phase: SCLK generator for SPI mode 0.
//   clk_in, reset_in : system clock, synchronous active-high reset
//   en_in            : high while chip select is active; low holds SCLK low
//   sclk_out         : SCLK level (low for CLK_DIV cycles, then high for CLK_DIV)
//   rise_out         : one-cycle strobe, SCLK goes high at the next clk edge
//   fall_out         : one-cycle strobe, SCLK goes low at the next clk edge
module spi_clk_phase
  import spi_mem_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic en_in,
  output logic sclk_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          wrap;

  // Strobes lead the SCLK transition so the top level acts on the same edge.
  assign wrap     = en_in && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_out = wrap && !sclk_q;
  assign fall_out = wrap && sclk_q;
  assign sclk_out = sclk_q;

  always_ff @(posedge clk_in) begin
    if (reset_in || !en_in) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: single-request SPI memory controller (mode 0, NUM_CS selects).
//   clk_in / reset_in       : clock, synchronous active-high reset
//   req_valid_in/ready_out  : valid/ready request handshake
//   req_write_in, req_cs_sel_in, req_addr_in, req_len_in, wdata_in : request
//   rdata_out               : read bytes, byte i at [8i+:8], held until next read
//   done_out / err_out      : completion pulse / invalid-select flag
//   busy_out                : transaction in progress
//   sclk_out, mosi_out, miso_in, cs_out : SPI bus (cs_out active low)
//   state_dbg_out           : current FSM state
// Build option: SPI_MEM_CTRL_FAST_READ_EN selects opcode 0x0B plus 8 dummy
// clocks for reads; otherwise reads use 0x03 with no dummy phase.
//
// Handshake: a request is taken on an edge where req_valid_in && req_ready_out;
// all request fields are captured on that edge, and ready stays low until the
// transaction (including the CS-high gap) has finished.
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int NUM_CS    = 2,
  parameter int MAX_BYTES = 2,
  parameter int CLK_DIV   = 1
) (
  input  logic                                     clk_in,
  input  logic                                     reset_in,
  input  logic                                     req_valid_in,
  output logic                                     req_ready_out,
  input  logic                                     req_write_in,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] req_cs_sel_in,
  input  logic [ADDR_W-1:0]                        req_addr_in,
  input  logic [$clog2(MAX_BYTES):0]               req_len_in,
  input  logic [8*MAX_BYTES-1:0]                   wdata_in,
  output logic [8*MAX_BYTES-1:0]                   rdata_out,
  output logic                                     done_out,
  output logic                                     err_out,
  output logic                                     busy_out,
  output logic                                     sclk_out,
  output logic                                     mosi_out,
  input  logic                                     miso_in,
  output logic [NUM_CS-1:0]                        cs_out,
  output spi_mem_state_t                           state_dbg_out
);

  localparam int LEN_W  = $clog2(MAX_BYTES) + 1;
  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int TX_W   = 8 + SPI_ADDR_BITS + 8 + DATA_W;
  localparam int CNT_W  = $clog2(max_int(SPI_ADDR_BITS, DATA_W));
  localparam int GAP_W  = $clog2(2 * CLK_DIV);

`ifdef SPI_MEM_CTRL_FAST_READ_EN
  localparam logic [7:0] READ_OP    = SPI_CMD_FAST_READ;
  localparam bit         READ_DUMMY = 1'b1;
`else
  localparam logic [7:0] READ_OP    = SPI_CMD_READ;
  localparam bit         READ_DUMMY = 1'b0;
`endif

  spi_mem_state_t    state_q;
  logic              ready_q, busy_q, done_q, err_q, mosi_q, write_q, dummy_q;
  logic [NUM_CS-1:0] cs_q;
  logic [LEN_W-1:0]  len_q, len_eff;
  logic [TX_W-1:0]   tx_q, frame;
  logic [DATA_W-1:0] rx_q, rx_ordered, rdata_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [GAP_W-1:0]  gap_q;
  logic              sel_bad, cs_active, sclk, rise, fall, last_bit;
  int                phase_last;

  assign sel_bad   = int'(req_cs_sel_in) >= NUM_CS;
  assign cs_active = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_DUMMY) || (state_q == ST_DATA);

  // Zero length means one byte; anything above MAX_BYTES is clamped.
  always_comb begin
    if (req_len_in == '0)                   len_eff = LEN_W'(1);
    else if (int'(req_len_in) > MAX_BYTES)  len_eff = LEN_W'(MAX_BYTES);
    else                                    len_eff = req_len_in;
  end

  // Outgoing bit stream, left aligned: opcode, 24-bit address, then write data
  // (byte 0 first). Reads leave everything after the address zero, which also
  // covers the dummy byte and the read data phase.
  always_comb begin
    frame = '0;
    frame[TX_W-1 -: 8]              = req_write_in ? SPI_CMD_WRITE : READ_OP;
    frame[TX_W-9 -: SPI_ADDR_BITS]  = SPI_ADDR_BITS'(req_addr_in);
    if (req_write_in) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        frame[TX_W-33-8*i -: 8] = wdata_in[8*i +: 8];
      end
    end
  end

  // Received bits shift in at the bottom, so byte 0 ends up highest of the
  // len_q valid bytes; reverse the byte order and zero the unused bytes.
  always_comb begin
    rx_ordered = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(len_q)) rx_ordered[8*i +: 8] = rx_q[8*(int'(len_q)-1-i) +: 8];
    end
  end

  always_comb begin
    case (state_q)
      ST_ADDR: phase_last = SPI_ADDR_BITS - 1;
      ST_DATA: phase_last = 8 * int'(len_q) - 1;
      default: phase_last = 7;
    endcase
  end
  assign last_bit = (int'(bit_cnt_q) == phase_last);

  spi_clk_phase #(.CLK_DIV(CLK_DIV)) u_clk_phase (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .en_in    (cs_active),
    .sclk_out (sclk),
    .rise_out (rise),
    .fall_out (fall)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mosi_q    <= 1'b0;
      write_q   <= 1'b0;
      dummy_q   <= 1'b0;
      cs_q      <= '1;
      len_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_in) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (sel_bad) begin
              // No bus activity: report the error on the very next cycle.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              gap_q   <= '0;
            end else begin
              state_q   <= ST_CMD;
              cs_q      <= ~(NUM_CS'(1) << req_cs_sel_in);
              mosi_q    <= frame[TX_W-1];
              tx_q      <= {frame[TX_W-2:0], 1'b0};
              rx_q      <= '0;
              bit_cnt_q <= '0;
              len_q     <= len_eff;
              write_q   <= req_write_in;
              dummy_q   <= READ_DUMMY && !req_write_in;
            end
          end
        end
        ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
          if (rise && (state_q == ST_DATA)) rx_q <= {rx_q[DATA_W-2:0], miso_in};
          if (fall) begin
            mosi_q    <= tx_q[TX_W-1];
            tx_q      <= {tx_q[TX_W-2:0], 1'b0};
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              case (state_q)
                ST_CMD:   state_q <= ST_ADDR;
                ST_ADDR:  state_q <= dummy_q ? ST_DUMMY : ST_DATA;
                ST_DUMMY: state_q <= ST_DATA;
                default: begin
                  state_q <= ST_DONE;
                  cs_q    <= '1;
                  mosi_q  <= 1'b0;
                  done_q  <= 1'b1;
                  gap_q   <= GAP_W'(2 * CLK_DIV - 1);
                  if (!write_q) rdata_q <= rx_ordered;
                end
              endcase
            end
          end
        end
        ST_DONE: begin
          // CS-high gap before the next request may be taken.
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_out = ready_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign err_out       = err_q;
  assign mosi_out      = mosi_q;
  assign sclk_out      = sclk;
  assign cs_out        = cs_q;
  assign rdata_out     = rdata_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: bench for spi_mem_ctrl with two instances
//   dut0: NUM_CS=2, MAX_BYTES=2, CLK_DIV=1
//   dut1: NUM_CS=3, MAX_BYTES=2, CLK_DIV=3 (allows an out-of-range select)
// Honours SPI_MEM_CTRL_FAST_READ_EN when defined for the whole build.
module tb_spi_mem_ctrl;
  import spi_mem_ctrl_pkg::*;

`ifdef SPI_MEM_CTRL_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        v0, w0, rdy0, dn0, er0, bz0, sc0, mo0, mi0;
  logic [0:0]  s0;
  logic [15:0] a0, wd0, rd0;
  logic [1:0]  l0, cs0;
  spi_mem_state_t st0;

  logic        v1, w1, rdy1, dn1, er1, bz1, sc1, mo1, mi1;
  logic [1:0]  s1, l1;
  logic [15:0] a1, wd1, rd1;
  logic [2:0]  cs1;
  spi_mem_state_t st1;

  spi_mem_ctrl #(.ADDR_W(16), .NUM_CS(2), .MAX_BYTES(2), .CLK_DIV(1)) dut0 (
    .clk_in(clk), .reset_in(rst), .req_valid_in(v0), .req_ready_out(rdy0),
    .req_write_in(w0), .req_cs_sel_in(s0), .req_addr_in(a0), .req_len_in(l0),
    .wdata_in(wd0), .rdata_out(rd0), .done_out(dn0), .err_out(er0), .busy_out(bz0),
    .sclk_out(sc0), .mosi_out(mo0), .miso_in(mi0), .cs_out(cs0), .state_dbg_out(st0));

  spi_mem_ctrl #(.ADDR_W(16), .NUM_CS(3), .MAX_BYTES(2), .CLK_DIV(3)) dut1 (
    .clk_in(clk), .reset_in(rst), .req_valid_in(v1), .req_ready_out(rdy1),
    .req_write_in(w1), .req_cs_sel_in(s1), .req_addr_in(a1), .req_len_in(l1),
    .wdata_in(wd1), .rdata_out(rd1), .done_out(dn1), .err_out(er1), .busy_out(bz1),
    .sclk_out(sc1), .mosi_out(mo1), .miso_in(mi1), .cs_out(cs1), .state_dbg_out(st1));

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_errors;
  logic [7:0]  exp_q[$];
  logic [15:0] rd_model[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic v, input logic w, input logic [1:0] s,
                       input logic [15:0] a, input logic [1:0] l, input logic [15:0] wd);
    if (d == 0) begin
      v0 = v; w0 = w; s0 = s[0]; a0 = a; l0 = l; wd0 = wd;
    end else begin
      v1 = v; w1 = w; s1 = s; a1 = a; l1 = l; wd1 = wd;
    end
  endtask

  task automatic set_miso(input int d, input logic b);
    if (d == 0) mi0 = b;
    else        mi1 = b;
  endtask

  task automatic sample(input int d, output logic sc, output logic mo, output logic [2:0] cs,
                        output logic dn, output logic er, output logic bz, output logic rdy,
                        output logic [15:0] rd);
    if (d == 0) begin
      sc = sc0; mo = mo0; cs = {1'b1, cs0}; dn = dn0; er = er0; bz = bz0; rdy = rdy0; rd = rd0;
    end else begin
      sc = sc1; mo = mo1; cs = cs1; dn = dn1; er = er1; bz = bz1; rdy = rdy1; rd = rd1;
    end
  endtask

  // One complete transaction against a slave model; called and returns at a negedge.
  task automatic run_txn(input int d, input logic wr, input logic [1:0] sel,
                         input logic [15:0] addr, input logic [1:0] len,
                         input logic [15:0] wdata, input logic [15:0] resp_in);
    int cd, ncs, el, nb, hdr, t, t_done, t_ready, cs_low, stray, rises, runlen, run_err, dup, waitc, j;
    logic bad, dm, prev, err_v, sc, mo, dn, er, bz, rdy, mb;
    logic [2:0]  cs;
    logic [15:0] rd, rd_done;
    logic [7:0]  op, gb, eb;
    logic        got_q[$];

    cd  = (d == 0) ? 1 : 3;
    ncs = (d == 0) ? 2 : 3;
    el  = (len == 2'd0) ? 1 : ((int'(len) > 2) ? 2 : int'(len));
    bad = int'(sel) >= ncs;
    dm  = FAST && !wr;
    nb  = 8 * (4 + el + (dm ? 1 : 0));
    hdr = 8 * (4 + (dm ? 1 : 0));
    op  = wr ? 8'h02 : (FAST ? 8'h0B : 8'h03);

    exp_q.delete();
    if (!bad) begin
      exp_q.push_back(op);
      exp_q.push_back(8'h00);
      exp_q.push_back(addr[15:8]);
      exp_q.push_back(addr[7:0]);
      if (dm) exp_q.push_back(8'h00);
      for (int i = 0; i < el; i++) exp_q.push_back(wr ? wdata[8*i +: 8] : 8'h00);
    end

    waitc = 0;
    sample(d, sc, mo, cs, dn, er, bz, rdy, rd);
    while (!rdy && waitc < 100) begin
      @(negedge clk);
      sample(d, sc, mo, cs, dn, er, bz, rdy, rd);
      waitc++;
    end
    if (!rdy) begin
      check_eq("ready_wait", 0, 1);
      return;
    end
    drive(d, 1'b1, wr, sel, addr, len, wdata);
    set_miso(d, 1'($urandom));
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 16'h0);

    t = 1; t_done = -1; t_ready = -1; cs_low = 0; stray = 0; rises = 0;
    runlen = 0; run_err = 0; dup = 0; prev = 1'b0; err_v = 1'bx; rd_done = 'x;
    while (t <= 2 * cd * (nb + 1) + 10) begin
      sample(d, sc, mo, cs, dn, er, bz, rdy, rd);
      if (t == 1) begin
        check_eq("busy_start", bz, 1);
        check_eq("sclk_start", sc, 0);
        if (!bad) begin
          check_eq("cs_start", cs[sel], 0);
          check_eq("mosi_start", mo, op[7]);
        end
      end
      for (int b = 0; b < ncs; b++) begin
        if (cs[b] == 1'b0) begin
          if (!bad && b == int'(sel)) cs_low++;
          else stray++;
        end
      end
      if (t > 1 && sc != prev) begin
        if (runlen != cd) run_err++;
        runlen = 1;
      end else begin
        runlen++;
      end
      if (sc && !prev) begin
        got_q.push_back(mo);
        rises++;
        if (rises >= hdr && rises < hdr + 8 * el) mb = resp_in[8*((rises-hdr)/8) + 7 - ((rises-hdr)%8)];
        else mb = 1'($urandom);
        set_miso(d, mb);
      end
      if (dn) begin
        if (t_done < 0) begin
          t_done = t; err_v = er; rd_done = rd;
        end else begin
          dup++;
        end
      end
      if (rdy && t > 1) begin
        t_ready = t;
        check_eq("busy_end", bz, 0);
        break;
      end
      prev = sc;
      @(negedge clk);
      t++;
    end

    check_eq("t_done",      t_done,  bad ? 1 : 1 + 2 * cd * nb);
    check_eq("t_ready",     t_ready, bad ? 2 : 1 + 2 * cd * (nb + 1));
    check_eq("err",         err_v,   bad);
    check_eq("dup_done",    dup,     0);
    check_eq("cs_low_cyc",  cs_low,  bad ? 0 : 2 * cd * nb);
    check_eq("cs_other",    stray,   0);
    check_eq("sclk_rises",  rises,   bad ? 0 : nb);
    check_eq("sclk_period", run_err, 0);
    check_eq("mosi_bits",   got_q.size(), 8 * exp_q.size());
    j = 0;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      if (8 * j + 7 < got_q.size()) begin
        gb = 8'h00;
        for (int b = 0; b < 8; b++) gb = {gb[6:0], got_q[8*j+b]};
        check_eq($sformatf("mosi_byte%0d", j), gb, eb);
      end
      j++;
    end
    if (!bad && !wr) begin
      rd_model[d] = 16'h0;
      for (int i = 0; i < el; i++) rd_model[d][8*i +: 8] = resp_in[8*i +: 8];
    end
    check_eq("rdata", rd_done, rd_model[d]);
  endtask

  // Reset asserted in the middle of the address phase of a dut0 read.
  task automatic reset_mid();
    logic sc, mo, dn, er, bz, rdy;
    logic [2:0]  cs;
    logic [15:0] rd;
    int waitc;
    waitc = 0;
    sample(0, sc, mo, cs, dn, er, bz, rdy, rd);
    while (!rdy && waitc < 100) begin
      @(negedge clk);
      sample(0, sc, mo, cs, dn, er, bz, rdy, rd);
      waitc++;
    end
    drive(0, 1'b1, 1'b0, 2'd0, 16'h1234, 2'd2, 16'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 16'h0);
    repeat (19) @(negedge clk);
    check_eq("mid_state", st0, ST_ADDR);
    rst = 1'b1;
    @(negedge clk);
    sample(0, sc, mo, cs, dn, er, bz, rdy, rd);
    check_eq("rst_cs",    cs[1:0], 2'b11);
    check_eq("rst_sclk",  sc, 0);
    check_eq("rst_mosi",  mo, 0);
    check_eq("rst_ready", rdy, 1);
    check_eq("rst_done",  dn, 0);
    check_eq("rst_busy",  bz, 0);
    check_eq("rst_rdata", rd, 16'h0);
    check_eq("rst_state", st0, ST_IDLE);
    rst = 1'b0;
    rd_model[0] = 16'h0;
    rd_model[1] = 16'h0;
  endtask

  // ---------------- stimulus + report ----------------
  initial begin
    logic sc, mo, dn, er, bz, rdy;
    logic [2:0]  cs;
    logic [15:0] rd;
    int d;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 16'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 16'h0);
    mi0 = 1'b0;
    mi1 = 1'b0;
    rd_model[0] = 16'h0;
    rd_model[1] = 16'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sample(k, sc, mo, cs, dn, er, bz, rdy, rd);
      check_eq("init_cs",    cs, 3'b111);
      check_eq("init_sclk",  sc, 0);
      check_eq("init_mosi",  mo, 0);
      check_eq("init_ready", rdy, 1);
      check_eq("init_busy",  bz, 0);
      check_eq("init_done",  dn, 0);
      check_eq("init_err",   er, 0);
      check_eq("init_rdata", rd, 16'h0);
    end
    check_eq("init_state", st0, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    run_txn(0, 1'b0, 2'd0, 16'h1234, 2'd2, 16'h0000, 16'h3CA5);
    run_txn(0, 1'b1, 2'd1, 16'hF00F, 2'd1, 16'h005A, 16'h0000);
    run_txn(0, 1'b0, 2'd0, 16'h0042, 2'd0, 16'h0000, 16'h77C1);
    run_txn(0, 1'b0, 2'd1, 16'hBEEF, 2'd3, 16'h0000, 16'h9E18);
    run_txn(0, 1'b1, 2'd0, 16'h1357, 2'd3, 16'hC3A1, 16'h0000);
    run_txn(1, 1'b0, 2'd0, 16'h1234, 2'd1, 16'h0000, 16'h00D2);
    run_txn(1, 1'b0, 2'd3, 16'h2222, 2'd2, 16'h0000, 16'h4411);
    run_txn(1, 1'b1, 2'd2, 16'h8001, 2'd2, 16'hA55A, 16'h0000);
    reset_mid();
    run_txn(0, 1'b0, 2'd0, 16'h1234, 2'd2, 16'h0000, 16'h6B0F);

    for (int i = 0; i < 16; i++) begin
      d = i % 2;
      run_txn(d, 1'($urandom), 2'($urandom_range(0, (d == 0) ? 1 : 3)),
              16'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
